// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data SRAM responder.
// Holds the MMIO register map, the reset constants and the byte-merge helper.
package data_sram_responder_pkg;

  localparam logic [31:0] MMIO_BASE_ADDR = 32'hbfaf_0000;

  localparam logic [15:0] MMIO_LED     = 16'h0000;
  localparam logic [15:0] MMIO_SW      = 16'h0004;
  localparam logic [15:0] MMIO_NUM     = 16'h0008;
  localparam logic [15:0] MMIO_TIMER   = 16'h000c;
  localparam logic [15:0] MMIO_CMP     = 16'h0010;
  localparam logic [15:0] MMIO_STATUS  = 16'h0014;
  localparam logic [15:0] MMIO_SCRATCH = 16'h0018;

  localparam logic [31:0] CMP_RESET = 32'hffff_ffff;

  typedef enum logic [2:0] {
    REG_LED,
    REG_SW,
    REG_NUM,
    REG_TIMER,
    REG_CMP,
    REG_STATUS,
    REG_SCRATCH,
    REG_NONE
  } mmio_reg_e;

  typedef enum logic {
    SEL_RAM,
    SEL_MMIO
  } rd_sel_e;

  // Byte offsets are word-aligned before decoding; the low two address bits never select a register.
  function automatic mmio_reg_e decode_mmio(input logic [15:0] offset);
    logic [15:0] word_off;
    mmio_reg_e   sel;
    word_off = offset & 16'hfffc;
    case (word_off)
      MMIO_LED:     sel = REG_LED;
      MMIO_SW:      sel = REG_SW;
      MMIO_NUM:     sel = REG_NUM;
      MMIO_TIMER:   sel = REG_TIMER;
      MMIO_CMP:     sel = REG_CMP;
      MMIO_STATUS:  sel = REG_STATUS;
      MMIO_SCRATCH: sel = REG_SCRATCH;
      default:      sel = REG_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  we);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data SRAM request/response bus as seen between the CPU and its responder.
interface data_sram_responder_if;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output we, output addr, output wdata, input rdata);
  modport slave  (input en, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_responder_sram_byte_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module sram_byte_ram #(
  parameter int RAM_ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [RAM_ADDR_W-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**RAM_ADDR_W];
  logic [31:0] rdata_q;

  // Read data only moves on a read, so it holds across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == 4'b0000) rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: decodes CPU data accesses to on-chip RAM or the MMIO
// register file, and returns read data one cycle after the request.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          RAM_ADDR_W = 14,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_ADDR,
  parameter int          SW_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  data_sram_responder_if.slave bus,
  output logic [15:0]         led,
  output logic [31:0]         num_data,
  input  logic [SW_W-1:0]     switch,
  output logic                timer_hit,
  output logic                bad_addr
);

  logic      req_mmio;
  logic      req_ram;
  logic      is_read;
  logic      hit_clear;
  mmio_reg_e mmio_reg;
  logic [31:0] ram_rdata;

  logic [15:0]     led_q, led_d;
  logic [31:0]     num_q, num_d;
  logic [31:0]     timer_q, timer_d;
  logic [31:0]     cmp_q, cmp_d;
  logic [31:0]     scratch_q, scratch_d;
  logic            hit_q, hit_d;
  logic [SW_W-1:0] sw_meta_q, sw_meta_d;
  logic [SW_W-1:0] sw_sync_q, sw_sync_d;
  logic [31:0]     mmio_rdata_q, mmio_rdata_d;
  rd_sel_e         rd_sel_q, rd_sel_d;
  logic            bad_q, bad_d;

  assign req_mmio = bus.en && (bus.addr[31:16] == MMIO_BASE[31:16]);
  assign req_ram  = bus.en && !req_mmio;
  assign is_read  = (bus.we == 4'b0000);
  assign mmio_reg = decode_mmio(bus.addr[15:0]);
  assign hit_clear = req_mmio && (mmio_reg == REG_STATUS) && bus.we[0] && bus.wdata[0];

  sram_byte_ram #(
    .RAM_ADDR_W(RAM_ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (req_ram && !reset),
    .we    (bus.we),
    .addr  (bus.addr[RAM_ADDR_W+1:2]),
    .wdata (bus.wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    led_d        = led_q;
    num_d        = num_q;
    timer_d      = timer_q + 32'd1;
    cmp_d        = cmp_q;
    scratch_d    = scratch_q;
    hit_d        = hit_q;
    sw_meta_d    = switch;
    sw_sync_d    = sw_meta_q;
    mmio_rdata_d = mmio_rdata_q;
    rd_sel_d     = rd_sel_q;
    bad_d        = 1'b0;

    if (req_mmio) begin
      bad_d = (mmio_reg == REG_NONE);
      if (is_read) begin
        rd_sel_d = SEL_MMIO;
        case (mmio_reg)
          REG_LED:     mmio_rdata_d = {16'h0000, led_q};
          REG_SW:      mmio_rdata_d = 32'(sw_sync_q);
          REG_NUM:     mmio_rdata_d = num_q;
          REG_TIMER:   mmio_rdata_d = timer_q;
          REG_CMP:     mmio_rdata_d = cmp_q;
          REG_STATUS:  mmio_rdata_d = {31'h0, hit_q};
          REG_SCRATCH: mmio_rdata_d = scratch_q;
          default:     mmio_rdata_d = 32'h0;
        endcase
      end else begin
        case (mmio_reg)
          REG_LED: begin
            led_d[7:0]  = bus.we[0] ? bus.wdata[7:0]  : led_q[7:0];
            led_d[15:8] = bus.we[1] ? bus.wdata[15:8] : led_q[15:8];
          end
          REG_NUM:     num_d     = byte_merge(num_q, bus.wdata, bus.we);
          REG_TIMER:   timer_d   = byte_merge(timer_q, bus.wdata, bus.we);
          REG_CMP:     cmp_d     = byte_merge(cmp_q, bus.wdata, bus.we);
          REG_SCRATCH: scratch_d = byte_merge(scratch_q, bus.wdata, bus.we);
          default: ;
        endcase
      end
    end else if (req_ram && is_read) begin
      rd_sel_d = SEL_RAM;
    end

    // Compare uses pre-update values; a same-cycle set overrides a clear.
    if (hit_clear) hit_d = 1'b0;
    if (timer_q == cmp_q) hit_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q        <= '0;
      num_q        <= '0;
      timer_q      <= '0;
      cmp_q        <= CMP_RESET;
      scratch_q    <= '0;
      hit_q        <= 1'b0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      mmio_rdata_q <= '0;
      rd_sel_q     <= SEL_MMIO;
      bad_q        <= 1'b0;
    end else begin
      led_q        <= led_d;
      num_q        <= num_d;
      timer_q      <= timer_d;
      cmp_q        <= cmp_d;
      scratch_q    <= scratch_d;
      hit_q        <= hit_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      mmio_rdata_q <= mmio_rdata_d;
      rd_sel_q     <= rd_sel_d;
      bad_q        <= bad_d;
    end
  end

  assign bus.rdata = (rd_sel_q == SEL_MMIO) ? mmio_rdata_q : ram_rdata;
  assign led       = led_q;
  assign num_data  = num_q;
  assign timer_hit = hit_q;
  assign bad_addr  = bad_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed scenarios followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_data_sram_responder;

  localparam logic [31:0] BASE = 32'hbfaf_0000;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sw    = 8'h00;
  logic [15:0] led;
  logic [31:0] num_data;
  logic        timer_hit;
  logic        bad_addr;

  int tests = 0;
  int fails = 0;

  data_sram_responder_if bus();

  data_sram_responder #(
    .RAM_ADDR_W(14),
    .MMIO_BASE (32'hbfaf_0000),
    .SW_W      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .led       (led),
    .num_data  (num_data),
    .switch    (sw),
    .timer_hit (timer_hit),
    .bad_addr  (bad_addr)
  );

  always #5 clk = ~clk;

  // Behavioural model state: RAM as a sparse word map, MMIO as plain variables.
  logic [31:0] m_ram [int];
  logic [15:0] m_led;
  logic [31:0] m_num, m_timer, m_cmp, m_scratch, m_rdata;
  logic        m_hit, m_bad, m_known;
  logic [7:0]  m_meta, m_sync;

  initial begin
    m_known = 1'b0;
    m_led = '0; m_num = '0; m_timer = '0; m_cmp = '1; m_scratch = '0;
    m_rdata = '0; m_hit = 1'b0; m_bad = 1'b0; m_meta = '0; m_sync = '0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic modelEdge(input logic en, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    logic        mmio, rd, set_hit;
    logic [15:0] off;
    logic [31:0] rv, t;
    int          idx;
    if (reset) begin
      m_led = '0; m_num = '0; m_timer = '0; m_cmp = '1; m_scratch = '0;
      m_hit = 1'b0; m_meta = '0; m_sync = '0; m_rdata = '0; m_bad = 1'b0; m_known = 1'b1;
      return;
    end
    mmio = en && (addr[31:16] == BASE[31:16]);
    rd   = (we == 4'b0000);
    off  = addr[15:0] & 16'hfffc;
    idx  = int'(addr[15:2]);
    case (off)
      16'h00:  rv = {16'h0, m_led};
      16'h04:  rv = {24'h0, m_sync};
      16'h08:  rv = m_num;
      16'h0c:  rv = m_timer;
      16'h10:  rv = m_cmp;
      16'h14:  rv = {31'h0, m_hit};
      16'h18:  rv = m_scratch;
      default: rv = 32'h0;
    endcase
    if (en && rd) begin
      if (mmio) m_rdata = rv;
      else if (m_ram.exists(idx)) begin m_rdata = m_ram[idx]; m_known = 1'b1; end
      else m_known = 1'b0;
    end
    set_hit = (m_timer == m_cmp);
    if (mmio && off == 16'h14 && we[0] && wdata[0]) m_hit = 1'b0;
    if (set_hit) m_hit = 1'b1;
    if (mmio && !rd && off == 16'h0c) m_timer = merge(m_timer, wdata, we);
    else m_timer = m_timer + 32'd1;
    if (mmio && !rd) begin
      case (off)
        16'h00: begin t = merge({16'h0, m_led}, wdata, we); m_led = t[15:0]; end
        16'h08: m_num = merge(m_num, wdata, we);
        16'h10: m_cmp = merge(m_cmp, wdata, we);
        16'h18: m_scratch = merge(m_scratch, wdata, we);
        default: ;
      endcase
    end else if (en && !mmio && !rd) begin
      m_ram[idx] = merge(m_ram.exists(idx) ? m_ram[idx] : 32'h0, wdata, we);
    end
    m_sync = m_meta;
    m_meta = sw;
    m_bad  = mmio && (off > 16'h18);
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    @(negedge clk);
    bus.en = en; bus.we = we; bus.addr = addr; bus.wdata = wdata;
    @(posedge clk);
    modelEdge(en, we, addr, wdata);
    #1;
    if (m_known) checkOutput("rdata", bus.rdata, m_rdata);
    checkOutput("led", {16'h0, led}, {16'h0, m_led});
    checkOutput("num_data", num_data, m_num);
    checkOutput("timer_hit", {31'h0, timer_hit}, {31'h0, m_hit});
    checkOutput("bad_addr", {31'h0, bad_addr}, {31'h0, m_bad});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    applyStimulus(1'b1, we, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    applyStimulus(1'b1, 4'b0000, a, $urandom);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'($urandom), $urandom, $urandom);
  endtask

  function automatic logic [31:0] poolAddr(input int i);
    logic [15:0] upper;
    logic [13:0] widx;
    upper = 16'($urandom_range(0, 16'hffff));
    if (upper == BASE[31:16]) upper = 16'h0000;
    widx = 14'(14'h300 + i);
    return {upper, widx, 2'($urandom)};
  endfunction

  initial begin
    logic [15:0] offs [9];
    int          r;
    logic [3:0]  we;
    offs = '{16'h00, 16'h04, 16'h08, 16'h0c, 16'h10, 16'h14, 16'h18, 16'h1c, 16'h40};
    bus.en = 1'b0; bus.we = '0; bus.addr = '0; bus.wdata = '0;

    reset = 1'b1;
    applyStimulus(1'b1, 4'b0000, 32'h0000_0100, 32'h0);
    idle();
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    checkOutput("rst_hit", {31'h0, timer_hit}, 32'h0);
    reset = 1'b0;
    rd(BASE + 32'h10);
    checkOutput("rst_cmp", bus.rdata, 32'hffff_ffff);

    wr(32'h1c00_0100, 32'h1234_5678, 4'hf);
    rd(32'h1c00_0100);
    checkOutput("s1_full", bus.rdata, 32'h1234_5678);
    wr(32'h1c00_0100, 32'h0000_ab00, 4'b0010);
    rd(32'h1c00_0100);
    checkOutput("s1_lane1", bus.rdata, 32'h1234_ab78);

    wr(32'h0000_0200, 32'hdead_beef, 4'hf);
    rd(32'h0000_0200);
    checkOutput("s2_b2b", bus.rdata, 32'hdead_beef);
    rd(32'h0001_0200);
    checkOutput("s2_alias", bus.rdata, 32'hdead_beef);

    wr(BASE, 32'h0000_a5a5, 4'hf);
    checkOutput("s3_led_pin", {16'h0, led}, 32'h0000_a5a5);
    rd(BASE);
    checkOutput("s3_led_rd", bus.rdata, 32'h0000_a5a5);
    sw = 8'h3c;
    idle();
    idle();
    rd(BASE + 32'h4);
    checkOutput("s3_switch", bus.rdata, 32'h0000_003c);

    wr(BASE + 32'h0c, 32'd10, 4'hf);
    wr(BASE + 32'h10, 32'd15, 4'hf);
    repeat (4) idle();
    checkOutput("s4_not_yet", {31'h0, timer_hit}, 32'h0);
    wr(BASE + 32'h14, 32'h1, 4'b0001);
    checkOutput("s4_set_wins", {31'h0, timer_hit}, 32'h1);
    wr(BASE + 32'h14, 32'h1, 4'b0001);
    checkOutput("s4_cleared", {31'h0, timer_hit}, 32'h0);
    wr(BASE + 32'h0c, 32'hffff_ffff, 4'hf);
    repeat (3) idle();
    rd(BASE + 32'h0c);
    checkOutput("s4_wrap", bus.rdata, 32'h2);

    rd(BASE + 32'h40);
    checkOutput("s5_rdata", bus.rdata, 32'h0);
    checkOutput("s5_bad", {31'h0, bad_addr}, 32'h1);
    idle();
    checkOutput("s5_bad_drop", {31'h0, bad_addr}, 32'h0);
    wr(BASE + 32'h18, 32'h55aa_55aa, 4'hf);
    wr(BASE + 32'h40, 32'hffff_ffff, 4'hf);
    checkOutput("s5_bad_wr", {31'h0, bad_addr}, 32'h1);
    rd(BASE + 32'h18);
    checkOutput("s5_scratch", bus.rdata, 32'h55aa_55aa);
    rd(BASE);
    checkOutput("s5_led", bus.rdata, 32'h0000_a5a5);

    for (int i = 0; i < 8; i++) wr(poolAddr(i), $urandom, 4'hf);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
      r  = $urandom_range(0, 9);
      we = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom);
      if (r < 4) applyStimulus(1'b1, we, poolAddr($urandom_range(0, 7)), $urandom);
      else if (r < 8)
        applyStimulus(1'b1, we, BASE | {16'h0, offs[$urandom_range(0, 8)]} | 32'($urandom_range(0, 3)),
                      $urandom);
      else idle();
    end

    rd(BASE + 32'h0c);
    reset = 1'b1;
    applyStimulus(1'b1, 4'b0000, 32'h1c00_0100, 32'h0);
    checkOutput("s6_rdata", bus.rdata, 32'h0);
    checkOutput("s6_led", {16'h0, led}, 32'h0);
    checkOutput("s6_hit", {31'h0, timer_hit}, 32'h0);
    reset = 1'b0;
    rd(BASE + 32'h10);
    checkOutput("s6_cmp", bus.rdata, 32'hffff_ffff);
    rd(32'h1c00_0100);
    checkOutput("s6_ram_kept", bus.rdata, 32'h1234_ab78);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
